// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU execute unit: control codes, FSM states
// and the set-less-than helper used by SLT/SLTU.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_XOR  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_AND  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_e;

    // Width-independent less-than: an unsigned compare, corrected by the sign
    // bits when a signed compare is requested and the signs differ.
    function automatic logic alu_less(input logic a_msb, input logic b_msb,
                                      input logic ult, input logic is_signed);
        if (is_signed && (a_msb != b_msb))
            return a_msb;
        return ult;
    endfunction

    function automatic logic is_shift(input alu_ctrl_e c);
        return (c == ALU_SLL) || (c == ALU_SRL) || (c == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Combinational SLL/SRL/SRA of an XLEN word by a variable amount of AMT_W bits;
// used both as the per-cycle shift step and as the barrel shifter.
module alu_shift_step
    import alu_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned AMT_W = 1
) (
    input  logic [XLEN-1:0]  data_i,
    input  logic [AMT_W-1:0] amt_i,
    input  alu_ctrl_e        mode_i,
    output logic [XLEN-1:0]  data_o
);

    always_comb begin
        data_o = data_i;
        case (mode_i)
            ALU_SLL: data_o = data_i << amt_i;
            ALU_SRL: data_o = data_i >> amt_i;
            ALU_SRA: data_o = XLEN'($signed(data_i) >>> amt_i);
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/alu_seq_exec.sv
// Sequential ALU execute unit with valid/ready handshakes; shifts are iterative
// unless ALU_FAST_SHIFT_EN is defined, which selects a single-cycle barrel shifter.
module alu_seq_exec
    import alu_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam int unsigned SHW    = $clog2(XLEN);
    localparam int unsigned STEP_W = $clog2(SHIFT_STEP + 1);

    alu_state_e      state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;
    logic [SHW-1:0]  rem_q, rem_d;
    alu_ctrl_e       op_q, op_d;

    alu_ctrl_e       ctrl_e;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_res;
    logic            alu_illegal;
    logic [XLEN-1:0] shift_now;
    logic [SHW:0]    step_full;
    logic [XLEN-1:0] step_out;

    assign ctrl_e = alu_ctrl_e'(ctrl);
    assign shamt  = op_b[SHW-1:0];

`ifdef ALU_FAST_SHIFT_EN
    alu_shift_step #(
        .XLEN  (XLEN),
        .AMT_W (SHW)
    ) u_barrel (
        .data_i (op_a),
        .amt_i  (shamt),
        .mode_i (ctrl_e),
        .data_o (shift_now)
    );
    assign step_full = '0;
    assign step_out  = result_q;
`else
    // In IDLE only the k=0 shift completes directly, so op_a is the answer.
    assign shift_now = op_a;

    always_comb begin
        if ({1'b0, rem_q} < (SHW+1)'(SHIFT_STEP))
            step_full = {1'b0, rem_q};
        else
            step_full = (SHW+1)'(SHIFT_STEP);
    end

    alu_shift_step #(
        .XLEN  (XLEN),
        .AMT_W (STEP_W)
    ) u_step (
        .data_i (result_q),
        .amt_i  (step_full[STEP_W-1:0]),
        .mode_i (op_q),
        .data_o (step_out)
    );
`endif

    always_comb begin
        alu_res     = '0;
        alu_illegal = 1'b0;
        case (ctrl_e)
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_AND:  alu_res = op_a & op_b;
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  alu_res = shift_now;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}},
                                 alu_less(op_a[XLEN-1], op_b[XLEN-1], op_a < op_b, 1'b1)};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}},
                                 alu_less(op_a[XLEN-1], op_b[XLEN-1], op_a < op_b, 1'b0)};
            default: begin
                alu_res     = '0;
                alu_illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        rem_d     = rem_q;
        op_d      = op_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
`ifdef ALU_FAST_SHIFT_EN
                    result_d  = alu_res;
                    zero_d    = (alu_res == '0);
                    illegal_d = alu_illegal;
                    state_d   = ST_DONE;
`else
                    if (is_shift(ctrl_e) && (shamt != '0)) begin
                        result_d  = op_a;
                        rem_d     = shamt;
                        op_d      = ctrl_e;
                        illegal_d = 1'b0;
                        state_d   = ST_SHIFT;
                    end else begin
                        result_d  = alu_res;
                        zero_d    = (alu_res == '0);
                        illegal_d = alu_illegal;
                        state_d   = ST_DONE;
                    end
`endif
                end
            end
            ST_SHIFT: begin
                result_d = step_out;
                rem_d    = rem_q - step_full[SHW-1:0];
                if (rem_d == '0) begin
                    zero_d  = (step_out == '0);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
            rem_q     <= '0;
            op_q      <= ALU_ADD;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            rem_q     <= rem_d;
            op_q      <= op_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec: directed cases plus randomized operations
// compared with an arithmetic reference model (latency follows ALU_FAST_SHIFT_EN).
module tb_alu_seq_exec;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned SHIFT_STEP = 1;
    localparam int unsigned SHW        = $clog2(XLEN);

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      ctrl;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    int checks   = 0;
    int failures = 0;

    alu_seq_exec #(
        .XLEN       (XLEN),
        .SHIFT_STEP (SHIFT_STEP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ctrl      (ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [XLEN-1:0] obs,
                         input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] ref_result(input logic [3:0] c,
                                                   input logic [XLEN-1:0] a,
                                                   input logic [XLEN-1:0] b);
        int unsigned k;
        logic [XLEN-1:0] ones;
        k    = int'(b) & (XLEN - 1);
        ones = '1;
        case (c)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a ^ b;
            4'd3: return a | b;
            4'd4: return a & b;
            4'd5: return a << k;
            4'd6: return a >> k;
            4'd7: return (a >> k) | (a[XLEN-1] ? ~(ones >> k) : '0);
            4'd8: return ($signed(a) < $signed(b)) ? 1 : 0;
            4'd9: return (a < b) ? 1 : 0;
            default: return '0;
        endcase
    endfunction

    function automatic int exp_latency(input logic [3:0] c, input logic [XLEN-1:0] b);
        int unsigned k;
        k = int'(b) & (XLEN - 1);
`ifdef ALU_FAST_SHIFT_EN
        return 1;
`else
        if ((c >= 4'd5) && (c <= 4'd7) && (k != 0))
            return 1 + int'((k + SHIFT_STEP - 1) / SHIFT_STEP);
        return 1;
`endif
    endfunction

    // Issue one request, scramble inputs after acceptance, wait for the result
    // with a cycle bound, check it, then retire it. hold_cycles > 0 keeps
    // out_ready low that long while a competing request is presented.
    task automatic run_op(input string tag, input logic [3:0] c,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input int hold_cycles);
        logic [XLEN-1:0] exp_r;
        int lat;
        int exp_lat;
        exp_r   = ref_result(c, a, b);
        exp_lat = exp_latency(c, b);
        @(negedge clk);
        check({tag, "_in_ready"}, XLEN'(in_ready), 1);
        in_valid = 1'b1;
        ctrl     = c;
        op_a     = a;
        op_b     = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ctrl     = 4'($urandom);
        op_a     = $urandom;
        op_b     = $urandom;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, XLEN'(lat), XLEN'(exp_lat));
        check({tag, "_result"}, result, exp_r);
        check({tag, "_zero"}, XLEN'(zero), XLEN'(exp_r == '0));
        check({tag, "_illegal"}, XLEN'(illegal), XLEN'(c >= 4'd10));
        for (int i = 0; i < hold_cycles; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            ctrl     = 4'd0;
            op_a     = 32'h1234_5678;
            op_b     = 32'h1;
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, XLEN'(out_valid), 1);
            check({tag, "_hold_ready"}, XLEN'(in_ready), 0);
            check({tag, "_hold_result"}, result, exp_r);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_ret_valid"}, XLEN'(out_valid), 0);
        check({tag, "_ret_ready"}, XLEN'(in_ready), 1);
        if (hold_cycles > 0) begin
            repeat (2) @(posedge clk);
            #1;
            check({tag, "_no_phantom"}, XLEN'(out_valid), 0);
        end
    endtask

    initial begin
        logic [3:0] rc;
        logic [XLEN-1:0] ra;
        logic [XLEN-1:0] rb;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ctrl      = '0;
        op_a      = '0;
        op_b      = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", XLEN'(in_ready), 1);
        check("rst_out_valid", XLEN'(out_valid), 0);
        check("rst_result", result, 0);
        check("rst_zero", XLEN'(zero), 0);
        check("rst_illegal", XLEN'(illegal), 0);
        @(negedge clk);
        rst = 1'b0;

        run_op("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'h1, 0);
        run_op("sub_zero", 4'd1, 32'd5, 32'd5, 0);
        run_op("slt_neg", 4'd8, 32'hFFFF_FFFF, 32'h1, 0);
        run_op("sltu_neg", 4'd9, 32'hFFFF_FFFF, 32'h1, 0);
        run_op("xor", 4'd2, 32'h0000_F0F0, 32'h0000_FFFF, 0);
        run_op("sra_k3", 4'd7, 32'h8000_0000, 32'h23, 0);
        run_op("sll_k0", 4'd5, 32'hDEAD_BEEF, 32'h20, 0);
        run_op("srl_k31", 4'd6, 32'h8000_0001, 32'h1F, 0);
        run_op("sll_k31", 4'd5, 32'h0000_0003, 32'hFFFF_FFFF, 0);
        run_op("reserved", 4'd12, 32'h1234, 32'h5678, 0);
        run_op("hold", 4'd3, 32'hA5A5_0000, 32'h0000_5A5A, 5);

        // Reset in the middle of a long shift discards it.
        @(negedge clk);
        in_valid = 1'b1;
        ctrl     = 4'd6;
        op_a     = 32'hFFFF_FFFF;
        op_b     = 32'd31;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_out_valid", XLEN'(out_valid), 0);
        check("midrst_in_ready", XLEN'(in_ready), 1);
        check("midrst_result", result, 0);
        check("midrst_zero", XLEN'(zero), 0);
        check("midrst_illegal", XLEN'(illegal), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("midrst_no_emit", XLEN'(out_valid), 0);
        run_op("post_rst_add", 4'd0, 32'h0000_0010, 32'h0000_0022, 0);

        for (int n = 0; n < 60; n++) begin
            rc = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            if (n % 5 == 0) rb = ra;
            if (n % 7 == 0) ra = {1'b1, 31'($urandom)};
            run_op("rand", rc, ra, rb, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
